// File: rtl/traffic_conflict_monitor_if.sv
// Lamp lines from the traffic controller plus the monitor's fault/status outputs.
// master = controller/cabinet side, slave = conflict monitor.
interface traffic_conflict_monitor_if;
    logic       r1, y1, g1;
    logic       r2, y2, g2;
    logic       fault_clr;
    logic       fault;
    logic [3:0] fault_code;
    logic       armed;
    logic       cycle_done;
    logic [7:0] cycle_count;

    modport master (
        output r1, y1, g1, r2, y2, g2, fault_clr,
        input  fault, fault_code, armed, cycle_done, cycle_count
    );

    modport slave (
        input  r1, y1, g1, r2, y2, g2, fault_clr,
        output fault, fault_code, armed, cycle_done, cycle_count
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent safety checker for a 2-way signal: tracks both lamp phases and
// latches the first unsafe pattern, illegal transition or timing violation.
module traffic_conflict_monitor #(
    parameter int MIN_GREEN       = 3,
    parameter int MAX_GREEN       = 15,
    parameter int YELLOW_CYCLES   = 1,
    parameter int MIN_ALLRED      = 1,
    parameter int STARTUP_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_conflict_monitor_if.slave   bus
);
    typedef enum logic [1:0] {ARM, RUN, FAULT} state_t;
    typedef enum logic [1:0] {PH_R, PH_Y, PH_G} phase_t;
    typedef enum logic [1:0] {LG_NONE, LG_1, LG_2} last_t;

    localparam logic [7:0] MIN_G  = 8'(MIN_GREEN);
    localparam logic [7:0] MAX_G  = 8'(MAX_GREEN);
    localparam logic [7:0] YEL    = 8'(YELLOW_CYCLES);
    localparam logic [7:0] MIN_AR = 8'(MIN_ALLRED);
    localparam int         AW     = $clog2(STARTUP_TIMEOUT + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(STARTUP_TIMEOUT - 1);

    state_t        state;
    phase_t        ph1, ph2;
    logic [7:0]    cnt1, cnt2, allred;
    logic          fresh1, fresh2, g2_done;
    last_t         last;
    logic [AW-1:0] arm_cnt;
    logic          fault_r, armed_r, done_r;
    logic [3:0]    code_r;
    logic [7:0]    count_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_R:    return PH_G;
            PH_G:    return PH_Y;
            default: return PH_R;
        endcase
    endfunction

    function automatic logic [3:0] min_code(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'd0) return b;
        if (b == 4'd0) return a;
        return (a < b) ? a : b;
    endfunction

    // Lowest violation among codes 3..8 for one direction; 0 when clean.
    function automatic logic [3:0] dir_check(input phase_t cur, input phase_t nxt,
                                             input logic [7:0] cnt, input logic fresh,
                                             input logic [7:0] ar, input logic same_last);
        logic [3:0] c;
        c = 4'd0;
        if (nxt != cur) begin
            if (nxt != next_phase(cur))                         c = 4'd3;
            else if (cur == PH_G && !fresh && cnt < MIN_G)      c = 4'd4;
            else if (cur == PH_Y && !fresh && cnt != YEL)       c = 4'd6;
            else if (nxt == PH_G && ar < MIN_AR)                c = 4'd7;
            else if (nxt == PH_G && same_last)                  c = 4'd8;
        end else begin
            if (cur == PH_G && sat_inc(cnt) > MAX_G)            c = 4'd5;
            else if (cur == PH_Y && sat_inc(cnt) > YEL)         c = 4'd6;
        end
        return c;
    endfunction

    logic       v1, v2, conflict, both_red;
    phase_t     p1, p2;
    logic [3:0] viol;

    assign v1       = $onehot({bus.r1, bus.y1, bus.g1});
    assign v2       = $onehot({bus.r2, bus.y2, bus.g2});
    assign conflict = (bus.g1 | bus.y1) & (bus.g2 | bus.y2);
    assign both_red = bus.r1 & bus.r2;
    assign p1       = bus.g1 ? PH_G : (bus.y1 ? PH_Y : PH_R);
    assign p2       = bus.g2 ? PH_G : (bus.y2 ? PH_Y : PH_R);

    always_comb begin
        viol = 4'd0;
        if (!v1 || !v2)    viol = 4'd1;
        else if (conflict) viol = 4'd2;
        else viol = min_code(dir_check(ph1, p1, cnt1, fresh1, allred, last == LG_1),
                             dir_check(ph2, p2, cnt2, fresh2, allred, last == LG_2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARM;
            ph1     <= PH_R;
            ph2     <= PH_R;
            cnt1    <= 8'd0;
            cnt2    <= 8'd0;
            allred  <= 8'd0;
            fresh1  <= 1'b0;
            fresh2  <= 1'b0;
            g2_done <= 1'b0;
            last    <= LG_NONE;
            arm_cnt <= '0;
            fault_r <= 1'b0;
            armed_r <= 1'b0;
            done_r  <= 1'b0;
            code_r  <= 4'd0;
            count_r <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ARM: begin
                    if (v1 && v2 && !conflict) begin
                        // Adopt whatever phase is showing; its history is unknown.
                        state   <= RUN;
                        armed_r <= 1'b1;
                        ph1     <= p1;
                        ph2     <= p2;
                        cnt1    <= 8'd1;
                        cnt2    <= 8'd1;
                        allred  <= both_red ? 8'd1 : 8'd0;
                        last    <= (p1 == PH_G) ? LG_1 : ((p2 == PH_G) ? LG_2 : LG_NONE);
                        fresh1  <= 1'b1;
                        fresh2  <= 1'b1;
                        g2_done <= 1'b0;
                        arm_cnt <= '0;
                    end else if (arm_cnt == ARM_LAST) begin
                        state   <= FAULT;
                        fault_r <= 1'b1;
                        code_r  <= 4'd9;
                    end else begin
                        arm_cnt <= arm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (viol != 4'd0) begin
                        state   <= FAULT;
                        fault_r <= 1'b1;
                        armed_r <= 1'b0;
                        code_r  <= viol;
                    end else begin
                        ph1    <= p1;
                        ph2    <= p2;
                        cnt1   <= (p1 != ph1) ? 8'd1 : sat_inc(cnt1);
                        cnt2   <= (p2 != ph2) ? 8'd1 : sat_inc(cnt2);
                        fresh1 <= fresh1 && (p1 == ph1);
                        fresh2 <= fresh2 && (p2 == ph2);
                        allred <= both_red ? sat_inc(allred) : 8'd0;
                        if (ph2 == PH_G && p2 != PH_G) g2_done <= 1'b1;
                        if (p1 == PH_G && ph1 != PH_G) begin
                            last    <= LG_1;
                            g2_done <= 1'b0;
                            if (g2_done) begin
                                done_r  <= 1'b1;
                                count_r <= count_r + 8'd1;
                            end
                        end else if (p2 == PH_G && ph2 != PH_G) begin
                            last <= LG_2;
                        end
                    end
                end
                default: begin
                    if (bus.fault_clr) begin
                        state   <= ARM;
                        fault_r <= 1'b0;
                        code_r  <= 4'd0;
                        arm_cnt <= '0;
                        ph1     <= PH_R;
                        ph2     <= PH_R;
                        cnt1    <= 8'd0;
                        cnt2    <= 8'd0;
                        allred  <= 8'd0;
                        fresh1  <= 1'b0;
                        fresh2  <= 1'b0;
                        g2_done <= 1'b0;
                        last    <= LG_NONE;
                    end
                end
            endcase
        end
    end

    assign bus.fault       = fault_r;
    assign bus.fault_code  = code_r;
    assign bus.armed       = armed_r;
    assign bus.cycle_done  = done_r;
    assign bus.cycle_count = count_r;
endmodule
